rr_encoder4x2: RTL and testbench

- Registered 4-to-2 round-robin priority encoder with a valid/ready handshake on both sides.
- Accepts a 4-bit multi-hot request vector and emits the 2-bit index of the granted line, plus the one-hot grant and a no-request flag.
- Used upstream of decoder2x4: when out_zero=0, out_gnt equals the decoder2x4 output for out_idx.
- Rotating priority pointer gives fair service across successive requests.

---
 rtl/rr_encoder4x2_pkg.sv | 13 +
 rtl/rr_pick4.sv | 31 +++
 rtl/rr_encoder4x2.sv | 58 +++++
 tb/tb_rr_encoder4x2.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/rr_encoder4x2_pkg.sv
// rtl/rr_encoder4x2_pkg.sv - shared constants and result type for the round-robin encoder
package rr_encoder4x2_pkg;

  localparam int N     = 4;
  localparam int IDX_W = 2;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic [N-1:0]     gnt;
    logic             zero;
  } enc_res_t;

endpackage

// File: rtl/rr_pick4.sv
// rtl/rr_pick4.sv - combinational rotating-priority pick over four request lines
module rr_pick4
  import rr_encoder4x2_pkg::*;
(
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     gnt,
  output logic             none
);

  logic [2*N-1:0]   dbl;
  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;

  // Rotate right by ptr so that line ptr lands on bit 0 of rot.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N];

  always_comb begin
    off = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) off = i[IDX_W-1:0];
    end
  end

  assign none = (req == '0);
  assign idx  = off + ptr;
  assign gnt  = none ? '0 : (N'(1) << idx);

endmodule

// File: rtl/rr_encoder4x2.sv
// rtl/rr_encoder4x2.sv - registered 4-to-2 round-robin encoder with valid/ready handshakes
module rr_encoder4x2
  import rr_encoder4x2_pkg::*;
#(
  parameter logic [IDX_W-1:0] PTR_RST = 2'd0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_req,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_gnt,
  output logic             out_zero,
  output logic             out_valid,
  input  logic             out_ready
);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_gnt;
  logic             pick_none;
  logic             accept;
  enc_res_t         res_q;

  rr_pick4 u_pick (
    .req  (in_req),
    .ptr  (ptr),
    .idx  (pick_idx),
    .gnt  (pick_gnt),
    .none (pick_none)
  );

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res_q     <= '0;
      ptr       <= PTR_RST;
    end else if (accept) begin
      out_valid <= 1'b1;
      res_q.idx <= pick_none ? '0 : pick_idx;
      res_q.gnt <= pick_gnt;
      res_q.zero <= pick_none;
      // An empty request leaves the fairness pointer where it was.
      if (!pick_none) ptr <= pick_idx + 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign out_idx  = res_q.idx;
  assign out_gnt  = res_q.gnt;
  assign out_zero = res_q.zero;

endmodule

// File: tb/tb_rr_encoder4x2.sv
// tb/tb_rr_encoder4x2.sv - scoreboard bench for rr_encoder4x2
module tb_rr_encoder4x2;

  localparam logic [1:0] PTR_RST = 2'd0;

  typedef struct packed {
    logic [1:0] idx;
    logic [3:0] gnt;
    logic       zero;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] in_req;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] out_idx;
  logic [3:0] out_gnt;
  logic       out_zero;
  logic       out_valid;
  logic       out_ready;

  int   total = 0;
  int   bad   = 0;
  exp_t sbq[$];
  logic [1:0] mptr;
  int   rr_seq [5] = '{0, 1, 2, 3, 0};

  rr_encoder4x2 #(.PTR_RST(PTR_RST)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_req    (in_req),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_idx   (out_idx),
    .out_gnt   (out_gnt),
    .out_zero  (out_zero),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] dec2x4(input logic [1:0] i);
    case (i)
      2'd0: dec2x4 = 4'b0001;
      2'd1: dec2x4 = 4'b0010;
      2'd2: dec2x4 = 4'b0100;
      default: dec2x4 = 4'b1000;
    endcase
  endfunction

  task automatic step();
    exp_t e;
    logic [1:0] ln;
    @(negedge clk);
    if (out_valid && out_ready) begin
      check("sb_nonempty", sbq.size() != 0, 1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        check("sb_idx", out_idx, e.idx);
        check("sb_gnt", out_gnt, e.gnt);
        check("sb_zero", out_zero, e.zero);
      end
    end
    if (in_valid && in_ready) begin
      e = '{idx: 2'd0, gnt: 4'd0, zero: 1'b1};
      for (int k = 0; k < 4; k++) begin
        ln = mptr + k[1:0];
        if (in_req[ln] && e.zero) begin
          e.zero = 1'b0;
          e.idx  = ln;
          e.gnt  = dec2x4(ln);
        end
      end
      if (!e.zero) mptr = e.idx + 2'd1;
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    sbq.delete();
    mptr = PTR_RST;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    in_req    = 4'b0000;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    mptr      = PTR_RST;
    #2;
    check("rst_valid", out_valid, 0);
    check("rst_idx", out_idx, 0);
    check("rst_gnt", out_gnt, 0);
    check("rst_zero", out_zero, 0);
    check("rst_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    in_req = 4'b0100; in_valid = 1'b1;
    step();
    check("single_idx", out_idx, 2);
    check("single_gnt", out_gnt, 4'b0100);
    check("single_valid", out_valid, 1);
    check("single_zero", out_zero, 0);
    in_valid = 1'b0;
    step();
    check("drain_valid", out_valid, 0);

    do_reset();
    in_req = 4'b1111; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("rr_seq", out_idx, rr_seq[i]);
    end
    in_valid = 1'b0;
    step();

    do_reset();
    in_req = 4'b0100; in_valid = 1'b1;
    step();
    in_req = 4'b0011;
    step();
    check("wrap_idx0", out_idx, 0);
    step();
    check("wrap_idx1", out_idx, 1);

    in_req = 4'b1111;
    step();
    check("pre_zero_idx", out_idx, 2);
    in_req = 4'b0000;
    step();
    check("zero_flag", out_zero, 1);
    check("zero_gnt", out_gnt, 0);
    check("zero_valid", out_valid, 1);
    check("zero_idx", out_idx, 0);
    in_req = 4'b1111;
    step();
    check("post_zero_idx", out_idx, 3);

    in_req = 4'b1000;
    step();
    out_ready = 1'b0;
    in_req = 4'b0101;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_idx", out_idx, 3);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    in_req = 4'b0001;
    step();
    check("bp_idx", out_idx, 0);
    check("bp_valid", out_valid, 1);
    in_valid = 1'b0;
    step();

    in_req = 4'b0010; in_valid = 1'b1;
    step();
    out_ready = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("midhold_valid", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_valid", out_valid, 0);
    check("async_idx", out_idx, 0);
    check("async_gnt", out_gnt, 0);
    sbq.delete();
    mptr = PTR_RST;
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_req = 4'b1111; in_valid = 1'b1;
    step();
    check("post_rst_idx", out_idx, PTR_RST);
    in_valid = 1'b0;
    step();

    in_valid = 1'b1;
    for (int r = 0; r < 16; r++) begin
      in_req = r[3:0];
      step();
      if (!out_zero) check("dec_cross", dec2x4(out_idx), out_gnt);
      else check("dec_zero_gnt", out_gnt, 0);
    end
    in_valid = 1'b0;
    step();
    check("sb_drained", sbq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
